// File: rtl/uart_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Bit positions inside the status word returned at STAT_ADDR.
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_BUSY_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;

    localparam logic [31:0] DEFAULT_TX_ADDR   = 32'h0000_0400;
    localparam logic [31:0] DEFAULT_STAT_ADDR = 32'h0000_0404;

    function automatic logic [31:0] pack_status(input logic overflow,
                                                input logic empty,
                                                input logic busy,
                                                input logic full);
        logic [31:0] word;
        word                 = '0;
        word[STAT_OVF_BIT]   = overflow;
        word[STAT_EMPTY_BIT] = empty;
        word[STAT_BUSY_BIT]  = busy;
        word[STAT_FULL_BIT]  = full;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push when full and pop when
// empty are ignored so the caller never corrupts the pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_t,
    input  logic             rst_t,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);  // wraps modulo DEPTH (power of two)
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_t) begin
        // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
        if (rst_t) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk_t) begin
        // NOTE: storage is not reset; emptying the FIFO only needs the pointers and count cleared.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR queue bytes, a status
// word is readable at STAT_ADDR, and a four-state FSM serialises the queue.
module mmio_uart_tx
    import uart_mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] TX_ADDR      = DEFAULT_TX_ADDR,
    parameter logic [31:0] STAT_ADDR    = DEFAULT_STAT_ADDR
) (
    input  logic        clk_t,
    input  logic        rst_t,
    input  logic        mem_wr_t,
    input  logic [31:0] mem_addr_t,
    input  logic [31:0] mem_wdata_t,
    output logic [31:0] mem_rdata_t,
    output logic        tx_t,
    output logic        busy_t
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        overflow_q, overflow_d;

    logic        wr_tx;
    logic        wr_stat;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        baud_done;
    logic        unused_wdata;

    assign wr_tx        = mem_wr_t && (mem_addr_t == TX_ADDR);
    assign wr_stat      = mem_wr_t && (mem_addr_t == STAT_ADDR);
    // A store that finds the FIFO full is dropped even if the FSM pops at the same edge.
    assign fifo_push    = wr_tx & ~fifo_full;
    assign baud_done    = (baud_q == BAUD_LAST);
    assign unused_wdata = ^mem_wdata_t[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_t (clk_t),
        .rst_t (rst_t),
        .push  (fifo_push),
        .din   (mem_wdata_t[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame sequencing: next state, baud/bit counters, shift register and FIFO pop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame so frames stay 10 bit periods apart.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level follows the upcoming state so tx_t changes on the same edge as the state.
    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Sticky overflow flag; a coinciding set beats the clear.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_stat && mem_wdata_t[STAT_OVF_BIT]) begin
            overflow_d = 1'b0;
        end
        if (wr_tx && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    // State registers with synchronous reset taking priority over all updates.
    always_ff @(posedge clk_t) begin
        if (rst_t) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_t        = tx_q;
    assign busy_t      = (state_q != ST_IDLE);
    assign mem_rdata_t = (mem_addr_t == STAT_ADDR)
                       ? pack_status(overflow_q, fifo_empty, busy_t, fifo_full)
                       : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: frame table, status-read table and
// hand-written sequences for back-to-back frames, overflow, clear and reset.
module tb_mmio_uart_tx;

    localparam int          CPB       = 4;
    localparam logic [31:0] TX_ADDR   = 32'h0000_0400;
    localparam logic [31:0] STAT_ADDR = 32'h0000_0404;
    localparam logic [31:0] SHARED    = 32'h0000_0500;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    // Second instance whose data and status registers share one address, so a
    // single store can both overflow and request a clear at the same edge.
    logic        wr2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic        tx2;
    logic        busy2;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .TX_ADDR      (TX_ADDR),
        .STAT_ADDR    (STAT_ADDR)
    ) dut (
        .clk_t       (clk),
        .rst_t       (rst),
        .mem_wr_t    (wr),
        .mem_addr_t  (addr),
        .mem_wdata_t (wdata),
        .mem_rdata_t (rdata),
        .tx_t        (tx),
        .busy_t      (busy)
    );

    mmio_uart_tx #(
        .CLKS_PER_BIT (2),
        .FIFO_DEPTH   (2),
        .TX_ADDR      (SHARED),
        .STAT_ADDR    (SHARED)
    ) dut2 (
        .clk_t       (clk),
        .rst_t       (rst),
        .mem_wr_t    (wr2),
        .mem_addr_t  (SHARED),
        .mem_wdata_t (wdata2),
        .mem_rdata_t (rdata2),
        .tx_t        (tx2),
        .busy_t      (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;   // bits[i] = line level during bit period i (start first)
    } frame_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } stat_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_status(output logic [31:0] val);
        wr   = 1'b0;
        addr = STAT_ADDR;
        #1;
        val = rdata;
    endtask

    // Check tx/busy for a whole frame starting at its first START cycle, skipping
    // the first 'skip' cycles when the caller is already part-way in.
    task automatic check_frame(input string tag, input logic [9:0] bits, input int skip);
        for (int c = skip; c < 10 * CPB; c++) begin
            check($sformatf("%s tx bit%0d cyc%0d", tag, c / CPB, c % CPB), {31'b0, tx}, {31'b0, bits[c / CPB]});
            check($sformatf("%s busy cyc%0d", tag, c), {31'b0, busy}, 32'd1);
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        logic [31:0] st;
        check({tag, " idle tx"}, {31'b0, tx}, 32'd1);
        check({tag, " idle busy"}, {31'b0, busy}, 32'd0);
        read_status(st);
        check({tag, " idle status"}, st, 32'h4);
    endtask

    frame_vec_t frames [4];
    stat_vec_t  stats  [5];

    initial begin
        logic [31:0] st;
        int          waited;

        frames[0] = '{data: 8'h55, bits: 10'b1010101010};
        frames[1] = '{data: 8'h00, bits: 10'b1000000000};
        frames[2] = '{data: 8'hFF, bits: 10'b1111111110};
        frames[3] = '{data: 8'hA3, bits: 10'b1101000110};

        stats[0] = '{addr: STAT_ADDR,     exp: 32'h0000_0004};
        stats[1] = '{addr: TX_ADDR,       exp: 32'h0000_0000};
        stats[2] = '{addr: 32'h0,         exp: 32'h0000_0000};
        stats[3] = '{addr: 32'h0000_0405, exp: 32'h0000_0000};
        stats[4] = '{addr: 32'h0000_0C04, exp: 32'h0000_0000};

        rst    = 1'b1;
        wr     = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        wr2    = 1'b0;
        wdata2 = 32'h0;
        tick();
        tick();

        // Reset state
        check("reset tx", {31'b0, tx}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        read_status(st);
        check("reset status", st, 32'h4);
        rst = 1'b0;
        tick();

        // Status reads at several addresses while idle and empty
        for (int i = 0; i < 5; i++) begin
            addr = stats[i].addr;
            #1;
            check($sformatf("rdata @%0h", stats[i].addr), rdata, stats[i].exp);
        end

        // Single frames: one cycle latency to the start bit, then 40-cycle frame
        for (int i = 0; i < 4; i++) begin
            string tag;
            tag   = $sformatf("frame %02h", frames[i].data);
            wr    = 1'b1;
            addr  = TX_ADDR;
            wdata = {24'h0, frames[i].data};
            tick();
            wr = 1'b0;
            check({tag, " tx before start"}, {31'b0, tx}, 32'd1);
            check({tag, " busy before start"}, {31'b0, busy}, 32'd0);
            tick();
            check_frame(tag, frames[i].bits, 0);
            check_idle(tag);
            tick();
        end

        // Back-to-back 0xA3 then 0x0F: no idle gap, second START 40 cycles later
        wr    = 1'b1;
        addr  = TX_ADDR;
        wdata = 32'hA3;
        tick();
        wdata = 32'h0F;
        tick();
        wr = 1'b0;
        check_frame("b2b A3", 10'b1101000110, 0);
        check_frame("b2b 0F", 10'b1000011110, 0);
        check_idle("b2b");
        tick();

        // Six stores while idle: 0x01 pops at once, 0x02..0x05 fill, 0x06 dropped
        addr = TX_ADDR;
        for (int i = 1; i <= 6; i++) begin
            wr    = 1'b1;
            wdata = i;
            tick();
        end
        wr = 1'b0;
        read_status(st);
        check("ovf status full", st, 32'hB);
        check_frame("ovf 01", 10'b1000000010, 4);
        check_frame("ovf 02", 10'b1000000100, 0);
        check_frame("ovf 03", 10'b1000000110, 0);
        check_frame("ovf 04", 10'b1000001000, 0);
        check_frame("ovf 05", 10'b1000001010, 0);
        check("ovf done tx", {31'b0, tx}, 32'd1);
        check("ovf done busy", {31'b0, busy}, 32'd0);
        read_status(st);
        check("ovf sticky", st, 32'hC);
        tick();

        // Store to status without bit 3 leaves overflow; with bit 3 clears it
        wr    = 1'b1;
        addr  = STAT_ADDR;
        wdata = 32'h7;
        tick();
        read_status(st);
        check("clear w/o bit3", st, 32'hC);
        wr    = 1'b1;
        addr  = STAT_ADDR;
        wdata = 32'h8;
        tick();
        read_status(st);
        check("clear with bit3", st, 32'h4);
        tick();

        // Same-edge overflow and clear on the shared-address instance: set wins
        wdata2 = 32'h08;
        for (int i = 0; i < 4; i++) begin
            wr2 = 1'b1;
            tick();
        end
        wr2 = 1'b0;
        #1;
        check("set beats clear status", rdata2, 32'hB);
        waited = 0;
        while (busy2 && waited < 200) begin
            tick();
            waited++;
        end
        check("dut2 drained in budget", {31'b0, busy2}, 32'd0);
        check("dut2 tx idle", {31'b0, tx2}, 32'd1);
        #1;
        check("dut2 ovf sticky", rdata2, 32'hC);
        tick();

        // Reset mid-DATA of 0xFF with two bytes queued
        wr    = 1'b1;
        addr  = TX_ADDR;
        wdata = 32'hFF;
        tick();
        wdata = 32'hA1;
        tick();
        wdata = 32'hB2;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre-reset tx in DATA", {31'b0, tx}, 32'd1);
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        read_status(st);
        check("pre-reset status", st, 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort tx", {31'b0, tx}, 32'd1);
        check("abort busy", {31'b0, busy}, 32'd0);
        read_status(st);
        check("abort status empty", st, 32'h4);
        check("abort dut2 status", rdata2, 32'h4);
        for (int i = 0; i < 60; i++) begin
            tick();
            check($sformatf("post-abort tx cyc%0d", i), {31'b0, tx}, 32'd1);
            check($sformatf("post-abort busy cyc%0d", i), {31'b0, busy}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have parameter TX_ADDR, default 32'h0000_0400, meaning the data register address.
REQ-004 The block SHALL have parameter STAT_ADDR, default 32'h0000_0404, meaning the status/control register address.
REQ-005 The block SHALL have port clk_t, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_t, input, 1 bit, a synchronous, active-high reset.
REQ-007 The block SHALL have port mem_wr_t, input, 1 bit, the processor data-memory store strobe.
REQ-008 The block SHALL have port mem_addr_t, input, 32 bits, the store/load address.
REQ-009 The block SHALL have port mem_wdata_t, input, 32 bits, the store data.
REQ-010 The block SHALL have port mem_rdata_t, output, 32 bits, the combinational status read: {28'b0, overflow, empty, busy, full} when mem_addr_t==STAT_ADDR, else 0.
REQ-011 The block SHALL have port tx_t, output, 1 bit, the registered serial line, idle high.
REQ-012 The block SHALL have port busy_t, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-013 A push SHALL occur when mem_wr_t=1, mem_addr_t==TX_ADDR and the FIFO is not full at that edge; the pushed byte is mem_wdata_t[7:0].
REQ-014 A store to TX_ADDR while full SHALL be dropped and SHALL set sticky overflow, even if a pop occurs at the same edge.
REQ-015 A store to STAT_ADDR with mem_wdata_t[3]=1 SHALL clear overflow; if a set and a clear coincide, set SHALL win.
REQ-016 Simultaneous push and pop with the FIFO neither full nor empty SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, STOP.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop into an 8-bit shift register and enter START at the same edge.
REQ-019 tx_t SHALL be 0 in START, shift-register bit 0 in DATA (LSB first), and 1 in STOP and IDLE.
REQ-020 Each state SHALL last exactly CLKS_PER_BIT cycles, counted by a baud counter running 0..CLKS_PER_BIT-1 and cleared on every state change.
REQ-021 DATA SHALL be held for 8 bit periods using a bit index 0..7; the register shifts right at each bit boundary.
REQ-022 At the final STOP cycle, the FSM SHALL pop and go directly to START if the FIFO is non-empty, otherwise go to IDLE.
REQ-023 Back-to-back frames SHALL therefore be spaced exactly 10*CLKS_PER_BIT cycles apart.
REQ-024 Latency: a push accepted at edge E SHALL make tx_t fall at edge E+1 when the FSM is IDLE.

Reset
REQ-025 While rst_t=1 at an edge: tx_t=1, busy_t=0, state=IDLE, FIFO pointers and count=0, overflow=0, baud counter and bit index=0.
REQ-026 Reset SHALL take priority over every push, pop and clear.
REQ-027 Reset mid-frame SHALL abort the frame; tx_t SHALL be high from the reset edge, and FIFO contents SHALL be discarded.

Structure
REQ-028 Package uart_mmio_pkg SHALL hold the FSM state typedef, the status bit positions and the default TX_ADDR/STAT_ADDR constants.
REQ-029 The FIFO SHALL be a sub-module, sync_fifo, parameterised by width 8 and FIFO_DEPTH, with full/empty/push/pop ports.

Verification
REQ-030 With CLKS_PER_BIT=4, store 0x55 to TX_ADDR -> tx_t reads 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, then idle high; busy_t is high for exactly 40 cycles.
REQ-031 Store 0xA3 then 0x0F on consecutive cycles -> two frames with no idle gap, the second START exactly 40 cycles after the first; status empty=1 afterwards.
REQ-032 Six consecutive stores (0x01..0x06) while idle, FIFO_DEPTH=4 -> the first pops immediately, bytes 2..5 fill the FIFO (full=1), 0x06 is dropped, overflow=1; 0x01..0x05 are serialised.
REQ-033 Store to STAT_ADDR with wdata 0x8 after overflow -> mem_rdata_t bit3 is 0 next cycle; a same-edge overflow and clear leaves bit3 at 1.
REQ-034 Assert rst_t for one cycle mid-DATA of a 0xFF frame with 2 bytes queued -> tx_t=1, busy_t=0, empty=1 next cycle, and no further frames are sent.
REQ-035 Read STAT_ADDR while idle and empty -> mem_rdata_t=32'h0000_0004; reading any other address -> 0.
